// File: rtl/pwm_output_stage_if.sv
// pwm_output_stage_if: groups the register-file enables/duty with the pad-side PWM outputs.
// Latency: none, wires only.
// No backpressure: the enables and duty are level signals and the outputs are free-running.
interface pwm_output_stage_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  // Register-file side: drives the enables and duty, observes the pins.
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  // PWM stage side.
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: one shared 8-bit PWM waveform muxed onto 16 registered pins (low / static high / PWM).
// Latency: enable and counter/duty-state changes reach out 1 clk later; PWM high-time starts 1 clk after period_start.
// No backpressure: free-running. Macro PWM_DUTY_SHADOW_EN latches the duty at each period wrap; otherwise the live duty is used.
module pwm_output_stage #(
  parameter int PRESCALE = 13
) (
  input logic               clk,
  input logic               rst,
  pwm_output_stage_if.slave bus
);

  // Prescaler width: clog2(PRESCALE), at least one bit so PRESCALE=1 still elaborates.
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc_cnt;
  logic [7:0]    r_pwm_cnt;
  logic [15:0]   r_out;
  logic          r_period_start;

  logic          w_tick;
  logic          w_wrap;
  logic          w_pwm_level;
  logic [7:0]    w_duty;
  logic [15:0]   w_en_out;
  logic [15:0]   w_en_pwm;
  logic [15:0]   w_out_nxt;

  assign w_tick   = (r_presc_cnt == PRESC_LAST);
  assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Prescaler: counts 0..PRESCALE-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PW'(1);
    end
  end

  // PWM step counter: advances on each tick and wraps naturally from 0xFF to 0x00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= 8'h00;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 8'h01;
    end
  end

  // Period marker: a single-cycle pulse on the edge where the counter wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] r_duty_sh;

  // Duty shadow: capture the requested duty only at the wrap so a period is never cut short or stretched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_sh <= 8'h00;
    end else if (w_wrap) begin
      r_duty_sh <= bus.pwm_duty_cycle;
    end
  end

  assign w_duty = r_duty_sh;
`else
  assign w_duty = bus.pwm_duty_cycle;
`endif

  // 0xFF is full-on; every other duty is high for exactly duty steps of the 256-step period.
  assign w_pwm_level = (w_duty == 8'hFF) || (r_pwm_cnt < w_duty);

  // Disabled pins are low regardless of PWM mode; enabled non-PWM pins are static high.
  assign w_out_nxt = w_en_out & (~w_en_pwm | {16{w_pwm_level}});

  // Pin register: the pads see a glitch-free, registered drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= 16'h0000;
    end else begin
      r_out <= w_out_nxt;
    end
  end

  assign bus.out          = r_out;
  assign bus.period_start = r_period_start;

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb_pwm_output_stage: randomized and directed stimulus against a time-based reference model.
// Latency: model predicts pins one clk after each edge's inputs.
// No backpressure: bench steps the clock and samples 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_pwm_output_stage;

  localparam int PRESCALE = 13;
  localparam int PERIOD   = 256 * PRESCALE;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_output_stage_if bus();

  pwm_output_stage #(.PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges elapsed since reset release and the duty in force for this period.
  int          m_t     = 0;
  logic [7:0]  m_dsh   = 8'h00;
  logic        exp_ps  = 1'b0;
  logic [15:0] exp_out = 16'h0000;

  // Measurements taken from the DUT pins.
  int hi_run  = 0;
  int last_hi = 0;
  int gap     = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, want, $time);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Advance one clock: predict from elapsed time, then compare the DUT pins.
  task automatic step();
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
    int          s;
    logic        lvl;
    eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    s  = (m_t / PRESCALE) % 256;
`ifdef PWM_DUTY_SHADOW_EN
    d = m_dsh;
`else
    d = bus.pwm_duty_cycle;
`endif
    lvl     = (d == 8'hFF) || (s < int'(d));
    exp_out = eo & (~ep | {16{lvl}});
    m_t++;
    exp_ps = ((m_t % PERIOD) == 0);
    if (exp_ps) m_dsh = bus.pwm_duty_cycle;
    @(posedge clk);
    #1;
    check("out", 32'(bus.out), 32'(exp_out));
    check("period_start", 32'(bus.period_start), 32'(exp_ps));
    hi_run += int'(bus.out[0]);
    gap++;
    if (bus.period_start) begin
      check("ps_gap", gap, PERIOD);
      gap = 0;
    end
    if (exp_ps) begin
      last_hi = hi_run;
      hi_run  = 0;
    end
  endtask

  task automatic run_to_wrap();
    do step(); while (!exp_ps);
  endtask

  task automatic run_to_step(input int s);
    while (((m_t % PERIOD) / PRESCALE) != s) step();
  endtask

  // Called 1 ns after an edge: checks the asynchronous clear, then releases away from any edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_async_out", 32'(bus.out), 32'h0);
    check("rst_async_ps", 32'(bus.period_start), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_out", 32'(bus.out), 32'h0);
    rst     = 1'b0;
    m_t     = 0;
    m_dsh   = 8'h00;
    gap     = 0;
    hi_run  = 0;
  endtask

  initial begin
    set_en(16'h0000, 16'h0000);
    bus.pwm_duty_cycle = 8'h00;
    #2;
    apply_reset();

    // Static enables.
    set_en(16'hA5A5, 16'h0000);
    step();
    check("static_a5a5", 32'(bus.out), 32'hA5A5);
    set_en(16'h0000, 16'hFFFF);
    step();
    check("static_off", 32'(bus.out), 32'h0000);
    set_en(16'hFFFF, 16'hFFFF);
    step();
    check("pre_wrap_low", 32'(bus.out), 32'h0000);

    // Duty 0x80: half period high.
    bus.pwm_duty_cycle = 8'h80;
    run_to_wrap();
    run_to_wrap();
    check("hi_80", last_hi, 1664);

    // Duty 0x00 over two periods.
    bus.pwm_duty_cycle = 8'h00;
    run_to_wrap();
    run_to_wrap();
    check("hi_00_a", last_hi, 0);
    run_to_wrap();
    check("hi_00_b", last_hi, 0);

    // Duty 0xFF: full on.
    bus.pwm_duty_cycle = 8'hFF;
    run_to_wrap();
    run_to_wrap();
    check("hi_ff", last_hi, PERIOD);

    // Duty 0x01: one step high.
    bus.pwm_duty_cycle = 8'h01;
    run_to_wrap();
    run_to_wrap();
    check("hi_01", last_hi, PRESCALE);

    // Mid-period duty write.
    bus.pwm_duty_cycle = 8'h40;
    run_to_wrap();
    run_to_step(16);
    bus.pwm_duty_cycle = 8'hC0;
    step();
    step();
    check("dutywr_still_hi", 32'(bus.out[0]), 32'h1);
    run_to_step(80);
`ifdef PWM_DUTY_SHADOW_EN
    check("dutywr_step50", 32'(bus.out[0]), 32'h0);
    run_to_wrap();
    check("hi_dutywr_cur", last_hi, 64 * PRESCALE);
`else
    check("dutywr_step50", 32'(bus.out[0]), 32'h1);
    run_to_wrap();
    check("hi_dutywr_cur", last_hi, 192 * PRESCALE);
`endif
    run_to_wrap();
    check("hi_dutywr_next", last_hi, 192 * PRESCALE);

    // Mixed pins.
    set_en(16'h00FF, 16'h000F);
    bus.pwm_duty_cycle = 8'h80;
    run_to_wrap();
    run_to_step(10);
    check("mixed_high_phase", 32'(bus.out), 32'h00FF);
    run_to_step(200);
    check("mixed_low_phase", 32'(bus.out), 32'h00F0);
    run_to_wrap();
    check("hi_mixed", last_hi, 1664);

    // Random enables and duty, checked every cycle by the model.
    for (int i = 0; i < 30; i++) begin
      set_en(16'($urandom), 16'($urandom));
      bus.pwm_duty_cycle = 8'($urandom);
      repeat ($urandom_range(1, 200)) step();
    end

    // Reset mid-period with pins driven.
    set_en(16'hFFFF, 16'h0000);
    step();
    check("pre_rst_out", 32'(bus.out), 32'hFFFF);
    apply_reset();
    bus.pwm_duty_cycle = 8'h80;
    set_en(16'hFFFF, 16'hFFFF);
    run_to_wrap();
    check("post_rst_gap", gap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of the SPI register file.
- Takes the output-enable, PWM-mode-enable and duty-cycle registers written over SPI, generates one shared 8-bit PWM waveform, and drives 16 registered output pins.
- Each pin is forced low, held static high, or driven with the PWM waveform, as selected by its enable bits.
- Sits between the SPI register block and the chip output pads.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step, ≥1. Default gives a 3328-cycle period, ≈3.005 kHz at 10 MHz clk.

Ports:
- clk  input  1  system clock; the same fast clock used by the SPI register block
- rst  input  1  reset, asynchronous, active-high
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  pin drive; out[7:0] from the *_7_0 registers, out[15:8] from the *_15_8 registers
- period_start  output  1  one-clk pulse when the PWM counter wraps to 0

Behaviour:
- Clocking: all inputs are synchronous to clk (same domain as the register block), so no synchronisers.
- Reset: while rst=1, all state clears asynchronously: prescaler=0, pwm_cnt=0, duty_sh=0x00, out=16'h0000, period_start=0.
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick=1 in the cycle where presc_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
  - Width is clog2(PRESCALE), minimum 1 bit.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 0xFF→0x00. Period = 256*PRESCALE clk.
- Wrap event: tick && pwm_cnt==0xFF.
  - On the same edge: pwm_cnt←0, duty_sh←pwm_duty_cycle, period_start←1.
  - period_start is 0 in all other cycles.
- PWM level (combinational):
  - duty_sh==0xFF gives pwm_level=1 (full on).
  - Otherwise pwm_level = (pwm_cnt < duty_sh).
  - Result: 0x00 is always low; 0x80 is high for exactly 128 of 256 steps.
- Pin mux, registered, for each pin i: out[i] ← en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0.
  - en_out=0 wins regardless of en_pwm.
- Latency:
  - Enable-register change: visible on out exactly 1 clk later.
  - pwm_cnt/duty_sh change: visible on out 1 clk later.
  - PWM high-time starts 1 clk after period_start rises.
- Duty update, with shadowing: a duty write mid-period has no effect until the next wrap, so every period is glitch-free.
- After reset, duty_sh=0: PWM pins stay low until the first wrap, then use the latched duty.
- Simultaneous events: an enable change in the wrap cycle uses the new enables and the old pwm_level for that edge's out update.
- Reset mid-period: counters restart from 0. The next period_start comes 256*PRESCALE clk after rst deasserts.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined:
  - duty_sh is used as above; duty changes apply only at the wrap event.
- Undefined:
  - duty_sh is removed and pwm_level compares directly against the live pwm_duty_cycle.
  - A duty change affects out 1 clk after the input changes, mid-period included.
  - Reset behaviour and all other behaviour are unchanged.

Test Plan:
- Reset: assert rst mid-run with out nonzero → out=0x0000 and period_start=0 immediately (async). After release, the first period_start comes at cycle 3328 (PRESCALE=13).
- Static enables: en_out=0xA5A5, en_pwm=0x0000 → out=0xA5A5 one clk later. Then en_out=0x0000 with en_pwm=0xFFFF → out=0x0000.
- Duty 0x80: en_out=en_pwm=0xFFFF, wait one wrap → every pin high for 1664 clk, low for 1664 clk per period. period_start is spaced 3328 clk apart.
- Boundaries:
  - Duty 0x00 → all PWM pins constantly low over 2 periods.
  - Duty 0xFF → constantly high.
  - Duty 0x01 → high exactly 13 clk per period.
- Shadowing (macro defined): duty 0x40 running, write 0xC0 at pwm_cnt=0x10 → current period stays 64 steps high; next period is 192 steps high. Macro undefined → change seen on out 1 clk after write.
- Mixed pins: en_out=0x00FF, en_pwm=0x000F, duty 0x80 → out[3:0] toggle, out[7:4] static 1, out[15:8] static 0.
